// File: rtl/booth_r4_multiplier_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// No storage; master drives operands and out_ready, slave returns results.
interface booth_r4_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output clear, in_valid, multiplicand, multiplier, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  clear, in_valid, multiplicand, multiplier, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands, one digit per cycle.
// Latency: product valid WIDTH/2+1 cycles after the accepting edge.
// Backpressure: holds product in DONE until out_ready; accepts operands only in IDLE.
module booth_r4_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    booth_r4_multiplier_if.slave   bus
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = WIDTH + 3;
    localparam int CW   = $clog2(ITER);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q;
    logic [AW-1:0]        a_q;
    logic [EW-1:0]        q_q;
    logic                 qm1_q;
    logic [EW-1:0]        br_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   prod_q;

    logic [AW-1:0]        m_sx;
    logic [AW-1:0]        addend;
    logic [AW-1:0]        sum;
    logic [AW-1:0]        a_d;
    logic [EW-1:0]        q_d;
    logic                 qm1_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [EW-1:0]        m_ext;
    logic [EW-1:0]        q_ext;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = prod_q;

    // Two guard bits make the unsigned case a positive signed number for Booth recoding.
    assign m_ext = bus.is_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};
    assign q_ext = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};

    always_comb begin
        m_sx   = {br_q[EW-1], br_q};
        addend = '0;
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_sx;
            3'b011:         addend = m_sx << 1;
            3'b100:         addend = -(m_sx << 1);
            3'b101, 3'b110: addend = -m_sx;
            default:        addend = '0;
        endcase
        sum    = a_q + addend;
        // Arithmetic shift of {A, Q, Q_-1} by two places.
        a_d    = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d    = {sum[1:0], q_q[EW-1:2]};
        qm1_d  = q_q[1];
        prod_d = {a_d[WIDTH-3:0], q_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            br_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else if (bus.clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            br_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        br_q    <= m_ext;
                        q_q     <= q_ext;
                        a_q     <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        prod_q  <= prod_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
